// File: rtl/uart_rx_byte_pkg.sv
// Shared definitions for the UART receive path and its downstream LED blink-count block.
package uart_rx_byte_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_IDLE = 3'd4
  } state_t;

  localparam int DEF_CLK_FREQ     = 27_000_000;
  localparam int DEF_BAUD         = 115_200;
  localparam int DEF_PACKAGE_SIZE = 8;
  localparam int LED_HALF_PERIOD  = DEF_CLK_FREQ / 2;

  // Index width for a counter over n items, never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous level input; reset value selectable.
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta <= RST_VAL;
      r_sync <= RST_VAL;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/uart_rx_byte.sv
// 8N1 UART receiver: mid-bit sampling of a synchronised RX line, one-cycle data/frame-error strobes.
module uart_rx_byte
  import uart_rx_byte_pkg::*;
#(
  parameter int CLK_FREQ     = DEF_CLK_FREQ,
  parameter int BAUD         = DEF_BAUD,
  parameter int PACKAGE_SIZE = DEF_PACKAGE_SIZE
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    rx,
  output logic [PACKAGE_SIZE-1:0] data,
  output logic                    data_ready,
  output logic                    frame_err
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int TICK_W       = $clog2(CLKS_PER_BIT);
  localparam int IDX_W        = idx_width(PACKAGE_SIZE);

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(CLKS_PER_BIT - 1);
  localparam logic [TICK_W-1:0] TICK_HALF = TICK_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TICK_W-1:0] TICK_ONE  = TICK_W'(1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(PACKAGE_SIZE - 1);
  localparam logic [IDX_W-1:0]  IDX_ONE   = IDX_W'(1);

  logic w_rx_s;

  state_t                  r_state, w_state_nxt;
  logic [TICK_W-1:0]       r_tick,  w_tick_nxt;
  logic [IDX_W-1:0]        r_bit,   w_bit_nxt;
  logic [PACKAGE_SIZE-1:0] r_shift, w_shift_nxt;
  logic [PACKAGE_SIZE-1:0] r_data,  w_data_nxt;
  logic                    r_ready, w_ready_nxt;
  logic                    r_ferr,  w_ferr_nxt;

  sync_2ff #(.RST_VAL(1'b1)) u_sync (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_d     (rx),
    .o_q     (w_rx_s)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_tick  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_data  <= '0;
      r_ready <= 1'b0;
      r_ferr  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_tick  <= w_tick_nxt;
      r_bit   <= w_bit_nxt;
      r_shift <= w_shift_nxt;
      r_data  <= w_data_nxt;
      r_ready <= w_ready_nxt;
      r_ferr  <= w_ferr_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_tick_nxt  = r_tick;
    w_bit_nxt   = r_bit;
    w_shift_nxt = r_shift;
    w_data_nxt  = r_data;
    w_ready_nxt = 1'b0;
    w_ferr_nxt  = 1'b0;
    case (r_state)
      IDLE: begin
        w_tick_nxt = '0;
        if (!w_rx_s) w_state_nxt = START;
      end
      START: begin
        // Re-check the line half a bit in so short glitches are rejected.
        if (r_tick == TICK_HALF) begin
          w_tick_nxt = '0;
          if (w_rx_s) begin
            w_state_nxt = IDLE;
          end else begin
            w_bit_nxt   = '0;
            w_state_nxt = DATA;
          end
        end else begin
          w_tick_nxt = r_tick + TICK_ONE;
        end
      end
      DATA: begin
        if (r_tick == TICK_LAST) begin
          w_tick_nxt         = '0;
          w_shift_nxt[r_bit] = w_rx_s;
          if (r_bit == IDX_LAST) begin
            w_state_nxt = STOP;
          end else begin
            w_bit_nxt = r_bit + IDX_ONE;
          end
        end else begin
          w_tick_nxt = r_tick + TICK_ONE;
        end
      end
      STOP: begin
        // Leaving mid stop bit leaves half a bit to catch a back-to-back start edge.
        if (r_tick == TICK_LAST) begin
          w_tick_nxt = '0;
          if (w_rx_s) begin
            w_data_nxt  = r_shift;
            w_ready_nxt = 1'b1;
            w_state_nxt = IDLE;
          end else begin
            w_ferr_nxt  = 1'b1;
            w_state_nxt = WAIT_IDLE;
          end
        end else begin
          w_tick_nxt = r_tick + TICK_ONE;
        end
      end
      WAIT_IDLE: begin
        w_tick_nxt = '0;
        if (w_rx_s) w_state_nxt = IDLE;
      end
      default: begin
        w_tick_nxt  = '0;
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign data       = r_data;
  assign data_ready = r_ready;
  assign frame_err  = r_ferr;

endmodule
